ascon_inv_permutation_iter: RTL and testbench

//  Iterative inverse Ascon permutation: computes p_a^-1 on a 320-bit state (x0..x4).

---
 rtl/ascon_inv_permutation_iter.sv | 143 ++++++++++++++
 tb/tb_ascon_inv_permutation_iter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_inv_permutation_iter.sv
// rtl/ascon_inv_permutation_iter.sv - iterative inverse Ascon permutation, one round per cycle
// Define ASCON_INV_UNROLL2_EN to apply two inverse rounds per RUN cycle.
module ascon_inv_permutation_iter #(
  parameter int MAX_ROUNDS = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [3:0]  rounds_i,
  input  logic [63:0] x0_i,
  input  logic [63:0] x1_i,
  input  logic [63:0] x2_i,
  input  logic [63:0] x3_i,
  input  logic [63:0] x4_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        err_o,
  output logic [63:0] x0_o,
  output logic [63:0] x1_o,
  output logic [63:0] x2_o,
  output logic [63:0] x3_o,
  output logic [63:0] x4_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [5:0] ROT_A [5] = '{6'd19, 6'd61, 6'd1, 6'd10, 6'd7};
  localparam logic [5:0] ROT_B [5] = '{6'd28, 6'd39, 6'd6, 6'd17, 6'd41};
  localparam logic [4:0] SINV [32] = '{
    5'h14, 5'h1a, 5'h07, 5'h0d, 5'h00, 5'h09, 5'h0e, 5'h12,
    5'h0a, 5'h06, 5'h1d, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1e,
    5'h18, 5'h16, 5'h0b, 5'h11, 5'h03, 5'h05, 5'h1c, 5'h1f,
    5'h17, 5'h1b, 5'h04, 5'h08, 5'h0f, 5'h0c, 5'h10, 5'h02
  };

  state_t        state, state_nxt;
  logic [319:0]  st, st_step;
  logic [3:0]    r, cnt, step;
  logic          err, accept, legal, last_step;

  function automatic logic [63:0] ror64(input logic [63:0] w, input logic [5:0] n);
    return (w >> n) | (w << (7'd64 - {1'b0, n}));
  endfunction

  // (1 + X^a + X^b)^63 is the inverse since the 64th power collapses to 1.
  function automatic logic [63:0] lin_inv(input logic [63:0] w, input logic [5:0] a,
                                          input logic [5:0] b);
    logic [63:0] t;
    t = w;
    for (int k = 0; k < 6; k++) t = t ^ ror64(t, a << k) ^ ror64(t, b << k);
    return t;
  endfunction

  function automatic logic [319:0] inv_round(input logic [319:0] s, input logic [3:0] rc);
    logic [63:0] x [5];
    logic [63:0] y [5];
    logic [4:0]  v;
    logic [7:0]  c;
    for (int i = 0; i < 5; i++) x[i] = lin_inv(s[319-64*i -: 64], ROT_A[i], ROT_B[i]);
    for (int j = 0; j < 64; j++) begin
      v = SINV[{x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]}];
      y[0][j] = v[4];
      y[1][j] = v[3];
      y[2][j] = v[2];
      y[3][j] = v[1];
      y[4][j] = v[0];
    end
    c = 8'hf0 - {rc, 4'h0} + {4'h0, rc};
    y[2] = y[2] ^ {56'd0, c};
    return {y[0], y[1], y[2], y[3], y[4]};
  endfunction

  assign legal  = (rounds_i != 4'd0) && (32'(rounds_i) <= MAX_ROUNDS);
  assign accept = valid_i && (state == IDLE);

  always_comb begin
`ifdef ASCON_INV_UNROLL2_EN
    if (cnt >= 4'd2) begin
      st_step = inv_round(inv_round(st, r), r - 4'd1);
      step    = 4'd2;
    end else begin
      st_step = inv_round(st, r);
      step    = 4'd1;
    end
    last_step = (cnt <= 4'd2);
`else
    st_step   = inv_round(st, r);
    step      = 4'd1;
    last_step = (cnt == 4'd1);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = legal ? RUN : DONE;
      RUN:     if (last_step) state_nxt = DONE;
      DONE:    if (ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st  <= '0;
      r   <= '0;
      cnt <= '0;
      err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          st  <= {x0_i, x1_i, x2_i, x3_i, x4_i};
          r   <= 4'd11;
          cnt <= rounds_i;
          err <= !legal;
        end
        RUN: begin
          st  <= st_step;
          r   <= r - step;
          cnt <= cnt - step;
        end
        DONE:    if (ready_i) err <= 1'b0;
        default: ;
      endcase
    end
  end

  assign ready_o = (state == IDLE);
  assign valid_o = (state == DONE);
  assign err_o   = err;
  assign x0_o    = st[319:256];
  assign x1_o    = st[255:192];
  assign x2_o    = st[191:128];
  assign x3_o    = st[127:64];
  assign x4_o    = st[63:0];

endmodule

// File: tb/tb_ascon_inv_permutation_iter.sv
// tb/tb_ascon_inv_permutation_iter.sv - round-trip bench for ascon_inv_permutation_iter
`timescale 1ns/1ps
module tb_ascon_inv_permutation_iter;

  typedef logic [4:0][63:0] st_t;
  typedef struct {
    string      name;
    logic [3:0] rnd;
    st_t        din;
    st_t        exp;
    logic       err;
    int         lat;
  } vec_t;

  logic        clk = 1'b0, rst_n = 1'b0, valid_i = 1'b0, ready_i = 1'b0;
  logic [3:0]  rounds_i = 4'd0;
  st_t         din_s = '0;
  logic        ready_o, valid_o, err_o;
  logic [63:0] x0_o, x1_o, x2_o, x3_o, x4_o;
  st_t         dout_s;

  int n_pass = 0, n_total = 0;
  int rot_a [5] = '{19, 61, 1, 10, 7};
  int rot_b [5] = '{28, 39, 6, 17, 41};
  logic [4:0] sinv [32] = '{
    5'h14, 5'h1a, 5'h07, 5'h0d, 5'h00, 5'h09, 5'h0e, 5'h12,
    5'h0a, 5'h06, 5'h1d, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1e,
    5'h18, 5'h16, 5'h0b, 5'h11, 5'h03, 5'h05, 5'h1c, 5'h1f,
    5'h17, 5'h1b, 5'h04, 5'h08, 5'h0f, 5'h0c, 5'h10, 5'h02};
  logic [4:0] sbox [32];
  vec_t vecs [$];

  assign dout_s = {x4_o, x3_o, x2_o, x1_o, x0_o};

  ascon_inv_permutation_iter dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o), .rounds_i(rounds_i),
    .x0_i(din_s[0]), .x1_i(din_s[1]), .x2_i(din_s[2]), .x3_i(din_s[3]), .x4_i(din_s[4]),
    .valid_o(valid_o), .ready_i(ready_i), .err_o(err_o),
    .x0_o(x0_o), .x1_o(x1_o), .x2_o(x2_o), .x3_o(x3_o), .x4_o(x4_o));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [329:0] act, input logic [329:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  function automatic logic [63:0] ror(input logic [63:0] w, input int n);
    logic [127:0] d;
    d = {w, w} >> n;
    return d[63:0];
  endfunction

  function automatic int exp_lat(input int a);
`ifdef ASCON_INV_UNROLL2_EN
    return (a + 1) / 2;
`else
    return a;
`endif
  endfunction

  // Forward p_a: constant, S-box, linear layer for rounds 12-a..11.
  task automatic calculate_permutation(input st_t s_in, input int a, output st_t s_out);
    st_t s, t;
    logic [4:0] o;
    s = s_in;
    for (int i = 12 - a; i < 12; i++) begin
      s[2] = s[2] ^ 64'((8'hf0 - i * 8'h10 + i) & 255);
      for (int j = 0; j < 64; j++) begin
        o = sbox[{s[0][j], s[1][j], s[2][j], s[3][j], s[4][j]}];
        t[0][j] = o[4]; t[1][j] = o[3]; t[2][j] = o[2]; t[3][j] = o[1]; t[4][j] = o[0];
      end
      for (int k = 0; k < 5; k++) s[k] = t[k] ^ ror(t[k], rot_a[k]) ^ ror(t[k], rot_b[k]);
    end
    s_out = s;
  endtask

  function automatic st_t rand_state();
    st_t s;
    for (int k = 0; k < 5; k++) s[k] = {$urandom(), $urandom()};
    return s;
  endfunction

  task automatic add_vec(input string name, input int a, input st_t orig);
    vec_t v;
    v.name = name;
    v.rnd  = 4'(a);
    v.exp  = orig;
    if (a >= 1 && a <= 12) begin
      calculate_permutation(orig, a, v.din);
      v.err = 1'b0;
      v.lat = exp_lat(a);
    end else begin
      v.din = orig;
      v.err = 1'b1;
      v.lat = 0;
    end
    vecs.push_back(v);
  endtask

  // Issues one request, waits for the result (bounded), optionally delays ready_i, then releases.
  task automatic run_req(input logic [3:0] rnd, input st_t d, input int hold,
                         output st_t q, output logic e, output int lat);
    @(negedge clk);
    rounds_i = rnd; din_s = d; valid_i = 1'b1; ready_i = (hold == 0);
    chk("ready_before_accept", 330'(ready_o), 330'(1));
    @(posedge clk); #1;
    valid_i = 1'b0;
    lat = 0;
    while (!valid_o && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    q = dout_s;
    e = err_o;
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      @(negedge clk);
      ready_i = 1'b1;
    end
    @(posedge clk); #1;
    chk("release_valid_err_ready", 330'({valid_o, err_o, ready_o}), 330'(3'b001));
    ready_i = 1'b0;
  endtask

  initial begin
    st_t s_ref, orig, fwd, q, q2;
    logic e;
    int lat, n1, n2, acc2, edges;
    logic pre, seen;
    int alist [3] = '{1, 6, 8};

    for (int v = 0; v < 32; v++) sbox[sinv[v]] = 5'(v);
    s_ref[0] = 64'h4523ee200ecf8b77; s_ref[1] = 64'he54828cae6d1d407;
    s_ref[2] = 64'h96771780123039c0; s_ref[3] = 64'h57fb8c67866bbd13;
    s_ref[4] = 64'h372004a82f4c80ff;

    add_vec("p12_S", 12, s_ref);
    add_vec("zero_a6", 6, '0);
    add_vec("zero_a8", 8, '0);
    add_vec("zero_a1", 1, '0);
    add_vec("zero_a12", 12, '0);
    add_vec("S_a7", 7, s_ref);
    add_vec("S_a1", 1, s_ref);
    add_vec("illegal_0", 0, s_ref);
    add_vec("illegal_13", 13, rand_state());
    add_vec("illegal_15", 15, '0);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctrl", 330'({valid_o, err_o, ready_o}), 330'(3'b001));
    chk("reset_x", 330'(dout_s), 330'(0));
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_req(vecs[i].rnd, vecs[i].din, i % 3, q, e, lat);
      chk({vecs[i].name, "_x"}, 330'(q), 330'(vecs[i].exp));
      chk({vecs[i].name, "_err"}, 330'(e), 330'(vecs[i].err));
      chk({vecs[i].name, "_lat"}, 330'(lat), 330'(vecs[i].lat));
    end

    for (int n = 0; n < 50; n++) begin
      foreach (alist[k]) begin
        orig = rand_state();
        calculate_permutation(orig, alist[k], fwd);
        run_req(4'(alist[k]), fwd, int'($urandom_range(0, 2)), q, e, lat);
        chk($sformatf("rand_a%0d_x", alist[k]), 330'(q), 330'(orig));
        chk($sformatf("rand_a%0d_err_lat", alist[k]), 330'({e, 8'(lat)}),
            330'({1'b0, 8'(exp_lat(alist[k]))}));
      end
    end

    // Backpressure on a legal and an illegal request, with stray valid_i pulses.
    for (int c = 0; c < 2; c++) begin
      orig = rand_state();
      if (c == 0) calculate_permutation(orig, 8, fwd);
      else fwd = orig;
      @(negedge clk);
      rounds_i = (c == 0) ? 4'd8 : 4'd0; din_s = fwd; valid_i = 1'b1; ready_i = 1'b0;
      @(posedge clk); #1;
      valid_i = 1'b0;
      lat = 0;
      while (!valid_o && lat < 40) begin
        @(posedge clk); #1;
        lat++;
      end
      for (int cyc = 0; cyc < 20; cyc++) begin
        @(negedge clk);
        valid_i = cyc[0]; rounds_i = 4'd1; din_s = rand_state();
        @(posedge clk); #1;
        chk("bp_hold", 330'({valid_o, err_o, ready_o, dout_s}), 330'({1'b1, c == 1, 1'b0, orig}));
      end
      @(negedge clk);
      valid_i = 1'b0; ready_i = 1'b1;
      @(posedge clk); #1;
      chk("bp_release", 330'({valid_o, err_o, ready_o}), 330'(3'b001));
      ready_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("bp_no_second_accept", 330'({valid_o, ready_o, dout_s}), 330'({1'b0, 1'b1, orig}));
    end

    // Reset pulse in the middle of an a=12 RUN.
    calculate_permutation(s_ref, 12, fwd);
    @(negedge clk);
    rounds_i = 4'd12; din_s = fwd; valid_i = 1'b1; ready_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", 330'({valid_o, err_o, ready_o, dout_s}), 330'({3'b001, 320'd0}));
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int cyc = 0; cyc < 15; cyc++) begin
      @(posedge clk); #1;
      seen = seen | valid_o;
    end
    chk("rst_no_output", 330'(seen), 330'(0));
    run_req(4'd12, fwd, 0, q, e, lat);
    chk("rst_next_req_x", 330'(q), 330'(s_ref));
    chk("rst_next_req_lat", 330'(lat), 330'(exp_lat(12)));

    // Back-to-back requests with ready_i tied high and valid_i held.
    orig = rand_state();
    s_ref = rand_state();
    calculate_permutation(orig, 3, fwd);
    calculate_permutation(s_ref, 5, q2);
    @(negedge clk);
    ready_i = 1'b1; valid_i = 1'b1; rounds_i = 4'd3; din_s = fwd;
    @(posedge clk); #1;
    rounds_i = 4'd5; din_s = q2;
    edges = 0; n1 = -1; n2 = -1; acc2 = -1; q = '0;
    while (edges < 60 && n2 < 0) begin
      @(negedge clk);
      pre = ready_o & valid_i;
      @(posedge clk); #1;
      edges++;
      if (pre && acc2 < 0) begin
        acc2 = edges;
        valid_i = 1'b0;
      end else if (valid_o) begin
        if (n1 < 0) begin
          n1 = edges;
          q = dout_s;
        end else if (acc2 >= 0) begin
          n2 = edges;
          q2 = dout_s;
        end
      end
    end
    chk("b2b_first_x", 330'(q), 330'(orig));
    chk("b2b_first_lat", 330'(n1), 330'(exp_lat(3)));
    chk("b2b_second_accept", 330'(acc2), 330'(n1 + 2));
    chk("b2b_second_x", 330'(q2), 330'(s_ref));
    chk("b2b_second_lat", 330'(n2 - acc2), 330'(exp_lat(5)));
    ready_i = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
